// File: rtl/pipe_ctl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: state encoding,
// register-number width and the source/destination match helper.
package pipe_ctl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

    localparam int REG_W = 5;
    localparam logic [0:REG_W-1] REG_ZERO = 5'd0;

    // True when an ID source field is actually read and names the given register.
    function automatic logic src_match(
        input logic             uses,
        input logic [0:REG_W-1] src,
        input logic [0:REG_W-1] dst
    );
        return uses & (src == dst);
    endfunction

endpackage

// File: rtl/hazard_mul_timer.sv
// Multi-cycle multiply occupancy timer: a RUN/MUL_BUSY FSM with a 4-bit
// down-counter that is frozen while the pipeline is held by memory.
module hazard_mul_timer
    import pipe_ctl_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic hold,
    output logic stall,
    output logic busy
);

    // Counter preload; a single-cycle multiply never leaves RUN, so its value is unused.
    localparam logic [3:0] CNT_INIT = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;

    mul_state_t state_r;
    logic [3:0] cnt_r;

    // State and remaining-cycle counter; both freeze while hold is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
            cnt_r   <= 4'd0;
        end else if (!hold) begin
            case (state_r)
                RUN: begin
                    if (start) begin
                        state_r <= MUL_BUSY;
                        cnt_r   <= CNT_INIT;
                    end
                end
                MUL_BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= RUN;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Stall in the start cycle and every busy cycle except the release cycle (cnt == 0).
    always_comb begin
        stall = 1'b0;
        if (state_r == RUN) begin
            stall = start;
        end else begin
            stall = (cnt_r != 4'd0);
        end
    end

    assign busy = (state_r == MUL_BUSY);

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline stall/flush controller: load-use detection, branch redirect squash,
// multi-cycle multiply hold and data-memory wait freeze, in fixed priority.
module pipe_hazard_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:REG_W-1] id_rs1,
    input  logic [0:REG_W-1] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic [0:REG_W-1] ex_destReg,
    input  logic             ex_RegWrite,
    input  logic             ex_MemToReg,
    input  logic             ex_mul,
    input  logic             ex_redirect,
    input  logic             dmem_wait,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mul_busy
);

    localparam logic MUL_MULTI = (MUL_LATENCY > 1) ? 1'b1 : 1'b0;

    logic mul_start_s;
    logic mul_stall_s;
    logic mul_busy_s;
    logic load_use_s;

    assign mul_start_s = ex_valid & ex_mul & MUL_MULTI & ~mul_busy_s;

    hazard_mul_timer #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_timer (
        .clk   (clk),
        .reset (reset),
        .start (mul_start_s),
        .hold  (dmem_wait),
        .stall (mul_stall_s),
        .busy  (mul_busy_s)
    );

    assign load_use_s = ex_valid & ex_MemToReg & ex_RegWrite & (ex_destReg != REG_ZERO)
                      & (src_match(id_uses_rs1, id_rs1, ex_destReg)
                       | src_match(id_uses_rs2, id_rs2, ex_destReg));

    // Priority encode the stall/flush controls; reset forces everything low at once.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (reset) begin
            pc_stall = 1'b0;
        end else if (dmem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mul_stall_s) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (load_use_s) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            pc_stall = 1'b0;
        end
    end

    assign mul_busy = mul_busy_s;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: a latency-4 and a latency-1 instance
// share stimulus and are compared against a cycle-age model every cycle.
module tb_pipe_hazard_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:4] id_rs1, id_rs2, ex_destReg;
    logic       id_uses_rs1, id_uses_rs2, ex_valid, ex_RegWrite, ex_MemToReg;
    logic       ex_mul, ex_redirect, dmem_wait;
    wire  [8:0] o4, o1;

    int n_tests = 0;
    int n_fail  = 0;
    int age4    = 0;
    int age1    = 0;
    int nst;

    always #5 clk = ~clk;

    pipe_hazard_ctl #(.MUL_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_destReg(ex_destReg), .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
        .ex_mul(ex_mul), .ex_redirect(ex_redirect), .dmem_wait(dmem_wait),
        .pc_stall(o4[8]), .if_id_stall(o4[7]), .id_ex_stall(o4[6]), .ex_mem_stall(o4[5]),
        .if_id_flush(o4[4]), .id_ex_flush(o4[3]), .ex_mem_flush(o4[2]), .mem_wb_flush(o4[1]),
        .mul_busy(o4[0])
    );

    pipe_hazard_ctl #(.MUL_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_destReg(ex_destReg), .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
        .ex_mul(ex_mul), .ex_redirect(ex_redirect), .dmem_wait(dmem_wait),
        .pc_stall(o1[8]), .if_id_stall(o1[7]), .id_ex_stall(o1[6]), .ex_mem_stall(o1[5]),
        .if_id_flush(o1[4]), .id_ex_flush(o1[3]), .ex_mem_flush(o1[2]), .mem_wb_flush(o1[1]),
        .mul_busy(o1[0])
    );

    // Model: age = number of non-waiting cycles the current multiply has spent in EX so far.
    function automatic logic [8:0] model(input int n, input int age);
        logic [3:0] st;
        logic [3:0] fl;
        logic       ms;
        logic       lu;
        st = 4'b0000;
        fl = 4'b0000;
        ms = ((age == 0) && ex_valid && ex_mul && (n > 1)) || ((age > 0) && (age < n - 1));
        lu = ex_valid && ex_MemToReg && ex_RegWrite && (ex_destReg != 5'd0) &&
             ((id_uses_rs1 && id_rs1 == ex_destReg) || (id_uses_rs2 && id_rs2 == ex_destReg));
        if (reset) return 9'd0;
        if (dmem_wait) begin st = 4'b1111; fl = 4'b0001; end
        else if (ex_redirect) fl = 4'b1100;
        else if (ms) begin st = 4'b1110; fl = 4'b0010; end
        else if (lu) begin st = 4'b1100; fl = 4'b0100; end
        return {st, fl, (age > 0)};
    endfunction

    function automatic int next_age(input int n, input int age);
        if (dmem_wait) return age;
        if (age == 0) return (ex_valid && ex_mul && n > 1) ? 1 : 0;
        if (age >= n - 1) return 0;
        return age + 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            age4 <= 0;
            age1 <= 0;
        end else begin
            age4 <= next_age(4, age4);
            age1 <= next_age(1, age1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_lat4", {23'd0, o4}, {23'd0, model(4, age4)});
        chk("model_lat1", {23'd0, o1}, {23'd0, model(1, age1)});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_destReg = 5'd0; ex_RegWrite = 1'b0; ex_MemToReg = 1'b0;
        ex_mul = 1'b0; ex_redirect = 1'b0; dmem_wait = 1'b0;
    endtask

    task automatic set_load(input logic [0:4] dst, input logic [0:4] rs2);
        ex_valid = 1'b1; ex_MemToReg = 1'b1; ex_RegWrite = 1'b1; ex_destReg = dst;
        id_rs2 = rs2; id_uses_rs2 = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        ex_valid = 1'b1; ex_mul = 1'b1; dmem_wait = 1'b1;
        cyc(); #3;
        chk("reset_lat4", {23'd0, o4}, 32'd0);
        chk("reset_lat1", {23'd0, o1}, 32'd0);

        // Load-use on rs2, then the bubble cycle, then the r0 case
        cyc(); idle(); reset = 1'b0; set_load(5'd3, 5'd3); #3;
        chk("load_use", {23'd0, o4}, {23'd0, 9'b1100_0100_0});
        cyc(); ex_valid = 1'b0; #3;
        chk("load_use_once", {23'd0, o4}, 32'd0);
        cyc(); idle(); set_load(5'd0, 5'd0); #3;
        chk("load_use_r0", {23'd0, o4}, 32'd0);

        // Multiply, latency 4 and latency 1
        cyc(); idle(); ex_valid = 1'b1; ex_mul = 1'b1; #3;
        chk("mul_c0", {23'd0, o4}, {23'd0, 9'b1110_0010_0});
        chk("mul1_c0", {23'd0, o1}, 32'd0);
        cyc(); #3; chk("mul_c1", {23'd0, o4}, {23'd0, 9'b1110_0010_1});
        chk("mul1_c1", {23'd0, o1}, 32'd0);
        cyc(); #3; chk("mul_c2", {23'd0, o4}, {23'd0, 9'b1110_0010_1});
        cyc(); #3; chk("mul_c3", {23'd0, o4}, {23'd0, 9'b0000_0000_1});
        cyc(); idle(); #3; chk("mul_c4", {23'd0, o4}, 32'd0);

        // Redirect wins over load-use
        cyc(); set_load(5'd7, 5'd7); ex_redirect = 1'b1; #3;
        chk("redirect", {23'd0, o4}, {23'd0, 9'b0000_1100_0});
        chk("redirect1", {23'd0, o1}, {23'd0, 9'b0000_1100_0});

        // Memory wait for 3 cycles starting in mul cycle 1
        cyc(); idle(); ex_valid = 1'b1; ex_mul = 1'b1; #3;
        chk("mw_c0", {23'd0, o4}, {23'd0, 9'b1110_0010_0});
        for (int k = 1; k <= 3; k++) begin
            cyc(); dmem_wait = 1'b1; #3;
            chk("mw_wait", {23'd0, o4}, {23'd0, 9'b1111_0001_1});
            chk("mw_wait1", {23'd0, o1}, {23'd0, 9'b1111_0001_0});
        end
        cyc(); dmem_wait = 1'b0; #3; chk("mw_c4", {23'd0, o4}, {23'd0, 9'b1110_0010_1});
        cyc(); #3; chk("mw_c5", {23'd0, o4}, {23'd0, 9'b1110_0010_1});
        cyc(); #3; chk("mw_release", {23'd0, o4}, {23'd0, 9'b0000_0000_1});
        cyc(); idle(); #3; chk("mw_run", {23'd0, o4}, 32'd0);

        // Asynchronous reset while busy with cnt == 1, then a fresh multiply
        cyc(); ex_valid = 1'b1; ex_mul = 1'b1;
        cyc(); cyc(); #3;
        chk("rst_pre", {23'd0, o4}, {23'd0, 9'b1110_0010_1});
        #2; reset = 1'b1; #1;
        chk("rst_async", {23'd0, o4}, 32'd0);
        cyc(); cyc(); reset = 1'b0; #3;
        nst = 0;
        for (int k = 0; k < 8; k++) begin
            if (o4[8] === 1'b1) nst++;
            else idle();
            cyc(); #3;
        end
        chk("rst_fresh_stalls", nst, 32'd3);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset       = ($urandom_range(0, 199) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_destReg  = 5'($urandom_range(0, 3));
            id_uses_rs1 = $urandom_range(0, 1) == 1;
            id_uses_rs2 = $urandom_range(0, 1) == 1;
            ex_valid    = $urandom_range(0, 3) != 0;
            ex_RegWrite = $urandom_range(0, 3) != 0;
            ex_MemToReg = $urandom_range(0, 1) == 1;
            ex_mul      = $urandom_range(0, 5) == 0;
            ex_redirect = !ex_mul && ($urandom_range(0, 7) == 0);
            dmem_wait   = $urandom_range(0, 7) == 0;
            if (age4 > 0) begin
                ex_valid = 1'b1; ex_mul = 1'b1; ex_redirect = 1'b0;
            end
        end
        cyc(); reset = 1'b0; idle();
        cyc(); #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Pipeline control unit that drives the stall (hold) and flush (bubble) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It is the producer side of the `ctl` interface those registers consume. It detects load-use hazards and taken branch/jump redirects, and holds the pipeline while a multi-cycle multiply occupies EX. It also freezes the whole pipeline on a data-memory wait. It sits beside the decode stage and takes register fields from ID and EX.

## Interface
Parameters:
- `MUL_LATENCY`, default 4: total cycles a `mul` instruction occupies EX. Legal range 1..16.

Ports (bit vectors are big-endian `[0:N-1]`):
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source register numbers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the ID instruction actually reads that source.
- `ex_valid`  in  1  EX holds a real (non-bubble) instruction.
- `ex_destReg`  in  5  destination register of the EX instruction.
- `ex_RegWrite`, `ex_MemToReg`  in  1 each  EX instruction writes a register / is a load.
- `ex_mul`  in  1  EX instruction is a multiply.
- `ex_redirect`  in  1  taken branch or jump resolved in EX.
- `dmem_wait`  in  1  data memory not ready; MEM must hold.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`  out  1 each  hold the register.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`  out  1 each  load a bubble.
- `mul_busy`  out  1  FSM is in MUL_BUSY.

## Operation
- FSM has two states, RUN and MUL_BUSY. It uses a 4-bit down-counter `cnt`.
- **mul_start** is `ex_valid & ex_mul & (MUL_LATENCY>1) & state==RUN`.
- **mul_stall** is `mul_start | (state==MUL_BUSY & cnt!=0)`.
- **Transitions** (these apply only when `dmem_wait`=0; with `dmem_wait`=1 the state and `cnt` hold):
  - RUN to MUL_BUSY on mul_start, loading `cnt`=MUL_LATENCY-2.
  - In MUL_BUSY, `cnt` decrements while nonzero. The state returns to RUN in the cycle `cnt`==0, which is the release cycle with no stall.
- **Load-use hazard** (`load_use`) is asserted when all of the following hold:
  - `ex_valid & ex_MemToReg & ex_RegWrite`, and `ex_destReg`!=0;
  - and either (`id_uses_rs1` & `id_rs1`==`ex_destReg`) or (`id_uses_rs2` & `id_rs2`==`ex_destReg`).
- **Output priority**, highest first:
  1. `dmem_wait`: all four stalls = 1, `mem_wb_flush` = 1, all other flushes = 0.
  2. `ex_redirect`: `if_id_flush` = 1 and `id_ex_flush` = 1; all stalls = 0.
  3. mul_stall: `pc_stall`, `if_id_stall` and `id_ex_stall` = 1, plus `ex_mem_flush` = 1.
  4. `load_use`: `pc_stall` and `if_id_stall` = 1, plus `id_ex_flush` = 1.
  5. Otherwise all outputs are 0.
- `ex_redirect` suppresses `load_use`, because the ID instruction is squashed.
- `ex_redirect` with `ex_mul` is illegal input and is not checked.
- Register 0 never causes a load-use hazard.

## Timing
- All stall and flush outputs are combinational from the inputs and the registered state, with no added latency. Pipeline registers sample them on the same `clk` edge.
- A mul with MUL_LATENCY=N holds EX for exactly N cycles and produces N-1 stall cycles. N=1 produces no stall and the FSM never leaves RUN.
- Load-use inserts exactly one bubble. On the next cycle the load is in MEM and `load_use` is deasserted.
- `mul_busy` is registered: it is 1 from the cycle after mul_start through the release cycle.
- **Reset values:**
  - While `reset` is high, state = RUN, `cnt` = 0 and every output = 0.
  - Asserting `reset` in MUL_BUSY drops all stalls immediately, asynchronously.
  - After reset release, behaviour resumes from RUN.
- A `dmem_wait` arriving during MUL_BUSY freezes `cnt`. The multiply stall resumes with the remaining count when `dmem_wait` drops.

## Structure
- Shared package `pipe_ctl_pkg` holds:
  - the state encoding, RUN = 0 and MUL_BUSY = 1;
  - `REG_W` = 5;
  - `REG_ZERO` = 5'd0.
- Sub-module `hazard_mul_timer` contains the FSM and `cnt`. Its ports are `start`, `hold`, `stall` and `busy`. The hazard and priority logic live in the top level.

## Test plan
- Load r3 in EX with `ex_destReg`=3; ID has `id_rs2`=3 and `id_uses_rs2`=1. Required: `pc_stall`=`if_id_stall`=`id_ex_flush`=1 for exactly one cycle. Repeat with `ex_destReg`=0: all outputs 0.
- Mul in EX with MUL_LATENCY=4. Required:
  - stalls and `ex_mem_flush` high for cycles 0..2 and low in cycle 3;
  - `mul_busy` high in cycles 1..3;
  - RUN in cycle 4.
- MUL_LATENCY=1 with a mul in EX. Required: no stall, and `mul_busy` stays 0.
- `ex_redirect`=1 in the same cycle as a load-use match. Required: `if_id_flush`=`id_ex_flush`=1, all stalls 0.
- Mul with MUL_LATENCY=4 and `dmem_wait`=1 for 3 cycles starting in cycle 1. Required:
  - all four stalls and `mem_wb_flush` high during the wait;
  - `cnt` holds at 2;
  - the release cycle arrives 3 cycles later than without the wait.
- Assert `reset` mid-MUL_BUSY (`cnt`=1). Required:
  - outputs go to 0 asynchronously;
  - after release, a fresh mul again gives 3 stall cycles.
